core_fpu_dispatch: RTL and testbench
====================================

Name: core_fpu_dispatch

Overview:
- Parametrised issue/retire engine between the multi-cycle core and NCH AXI4-Stream floating-point units (addsub, mul, div, comp).
- Accepts one operation at a time and routes operands and opcode to the selected channel.
- Holds each TVALID until its handshake completes, collects the result, and stalls the core until retirement.
- Replaces the per-unit ad-hoc valid/stall logic in the core top; also supports units without an OP stream.

Parameters:
- NCH, 4, number of FPU channels.
- DW, 32, operand/result width.
- OPW, 8, opcode stream width.
- CHW, 2, width of REQ_CH; must satisfy 2**CHW >= NCH.
- OP_MASK, 4'b1001, bit i=1 means channel i has an OP stream.
- TOW, 8, timeout counter width (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset.
- REQ_VALID  in  1  request strobe, sampled in IDLE only.
- REQ_CH  in  CHW  target channel.
- REQ_A  in  DW  operand A.
- REQ_B  in  DW  operand B.
- REQ_OP  in  OPW  opcode.
- BUSY  out  1  stall to core.
- DONE  out  1  one-cycle retire pulse.
- RESULT  out  DW  retired result, held until the next DONE.
- ERR  out  1  sticky abort flag.
- A_TDATA  out  NCH*DW;  A_TVALID  out  NCH;  A_TREADY  in  NCH.
- B_TDATA  out  NCH*DW;  B_TVALID  out  NCH;  B_TREADY  in  NCH.
- OP_TDATA  out  NCH*OPW;  OP_TVALID  out  NCH;  OP_TREADY  in  NCH.
- R_TDATA  in  NCH*DW;  R_TVALID  in  NCH;  R_TREADY  out  NCH.

Behaviour:
- Reset RST_N, synchronous, active-low; clock CLK.
- Reset values: state=IDLE; all TVALID, R_TREADY, BUSY, DONE, ERR = 0; all TDATA and RESULT = 0.
- Reset mid-operation drops every valid immediately. FPU IPs share RST_N, so no handshake completion is required.
- State machine, one-hot encoded: IDLE, ISSUE, WAIT, RETIRE.
- IDLE:
  - REQ_VALID=1 with REQ_CH<NCH: latch A, B, OP and CH; go to ISSUE.
  - Set the three per-stream pending flags. The OP flag is cleared at latch time if OP_MASK[CH]=0.
  - REQ_CH>=NCH: go to RETIRE with RESULT=0 and no stream activity.
- ISSUE:
  - Each pending stream drives TVALID=1 and TDATA for the selected channel only. All other channels drive TVALID=0 and TDATA=0.
  - A stream's flag clears at a posedge where TVALID&TREADY=1; its TVALID falls the next cycle.
  - TDATA is stable while TVALID=1.
  - When all flags are clear, go to WAIT. This includes the cycle where the last handshakes land simultaneously.
- WAIT:
  - R_TREADY[CH]=1; all other R_TREADY bits = 0.
  - On R_TVALID[CH]&R_TREADY[CH]: capture R_TDATA[CH] into RESULT and go to RETIRE.
  - R_TVALID on unselected channels is ignored.
- RETIRE: DONE=1 for exactly one cycle, then go to IDLE. REQ_VALID is ignored here.
- BUSY=1 in ISSUE and WAIT; BUSY=0 in IDLE and RETIRE.
  - The core asserts REQ_VALID in its EXECUTE state and must keep REQ_VALID low while BUSY=1.
- Minimum latency (all TREADY=1, result valid in the first WAIT cycle): REQ at cycle 0, ISSUE cycle 1, WAIT cycle 2, DONE cycle 3.
- REQ_VALID in any non-IDLE state has no effect; a new request is never queued.

Optional Feature:
- Macro: CORE_FPU_TIMEOUT_EN.
- Defined:
  - A TOW-bit counter clears on entering ISSUE and increments in ISSUE and WAIT.
  - At all-ones it aborts: all valids drop, RESULT=all-ones, go to RETIRE, ERR=1.
  - ERR stays set until the next accepted request clears it.
- Undefined: no counter, ERR tied 0, and a unit that never responds stalls the core indefinitely.

Decomposition:
- Package core_fpu_pkg holds:
  - state one-hot constants;
  - channel indices CH_ADDSUB=0, CH_MUL=1, CH_DIV=2, CH_COMP=3;
  - opcodes OP_FADD=8'h00, OP_FSUB=8'h01, OP_FEQ=8'h14, OP_FLT=8'h0C, OP_FLE=8'h1C.
- Sub-module core_axis_src_slot is a single-stream pending flag plus valid/data hold register, instantiated once each for A, B and OP.

Test Plan:
- CH=0, A=3F800000, B=40000000, OP=00, all ready, R_TVALID in the first WAIT cycle with 40400000 -> DONE at cycle 3, RESULT=40400000, BUSY high at cycles 1-2.
- CH=2 (OP_MASK bit 0): B_TREADY low for 5 cycles, A ready -> A_TVALID falls after 1 cycle, B_TVALID held 6 cycles with stable data, OP_TVALID never rises, DONE follows the result.
- CH=1 in flight, R_TVALID[3]=1 asserted spuriously -> ignored, R_TREADY[3]=0, RESULT comes only from channel 1.
- REQ_CH=5 with NCH=4 -> no TVALID on any channel, DONE at cycle 1, RESULT=0.
- RST_N low during WAIT -> next cycle all valids, BUSY and DONE = 0, state IDLE, and a new request proceeds normally.
- With CORE_FPU_TIMEOUT_EN and TOW=4: R_TVALID never arrives -> abort after 15 counted cycles, RESULT=FFFFFFFF, ERR=1, ERR cleared by the next request.

Source files
------------

// File: rtl/core_fpu_pkg.sv
// Shared types and constants for the core-to-FPU dispatch engine.
package core_fpu_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StIssue  = 4'b0010,
    StWait   = 4'b0100,
    StRetire = 4'b1000
  } fpu_state_e;

  localparam int unsigned CH_ADDSUB = 0;
  localparam int unsigned CH_MUL    = 1;
  localparam int unsigned CH_DIV    = 2;
  localparam int unsigned CH_COMP   = 3;

  localparam logic [7:0] OP_FADD = 8'h00;
  localparam logic [7:0] OP_FSUB = 8'h01;
  localparam logic [7:0] OP_FEQ  = 8'h14;
  localparam logic [7:0] OP_FLT  = 8'h0C;
  localparam logic [7:0] OP_FLE  = 8'h1C;

endpackage

// File: rtl/core_axis_src_slot.sv
// One AXI4-Stream source: pending flag plus a data register held stable while valid.
module core_axis_src_slot #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         need,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  input  logic         flush,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         pend_q, pend_d;
  logic [W-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    pend_d = pend_q;
    data_d = data_q;
    if (load) begin
      pend_d = need;
      data_d = need ? load_data : '0;
    end else if (flush || (pend_q && ready)) begin
      pend_d = 1'b0;
    end
  end

  assign valid = pend_q;
  assign data  = pend_q ? data_q : '0;

endmodule

// File: rtl/core_fpu_dispatch.sv
// Issue/retire engine routing one operation at a time to NCH AXI4-Stream FPU channels.
// Optional watchdog abort is enabled by defining CORE_FPU_TIMEOUT_EN.
module core_fpu_dispatch
  import core_fpu_pkg::*;
#(
  parameter int unsigned     NCH     = 4,
  parameter int unsigned     DW      = 32,
  parameter int unsigned     OPW     = 8,
  parameter int unsigned     CHW     = 2,
  parameter logic [NCH-1:0]  OP_MASK = 4'b1001,
  parameter int unsigned     TOW     = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               REQ_VALID,
  input  logic [CHW-1:0]     REQ_CH,
  input  logic [DW-1:0]      REQ_A,
  input  logic [DW-1:0]      REQ_B,
  input  logic [OPW-1:0]     REQ_OP,
  output logic               BUSY,
  output logic               DONE,
  output logic [DW-1:0]      RESULT,
  output logic               ERR,
  output logic [NCH*DW-1:0]  A_TDATA,
  output logic [NCH-1:0]     A_TVALID,
  input  logic [NCH-1:0]     A_TREADY,
  output logic [NCH*DW-1:0]  B_TDATA,
  output logic [NCH-1:0]     B_TVALID,
  input  logic [NCH-1:0]     B_TREADY,
  output logic [NCH*OPW-1:0] OP_TDATA,
  output logic [NCH-1:0]     OP_TVALID,
  input  logic [NCH-1:0]     OP_TREADY,
  input  logic [NCH*DW-1:0]  R_TDATA,
  input  logic [NCH-1:0]     R_TVALID,
  output logic [NCH-1:0]     R_TREADY
);

  fpu_state_e     state_q, state_d;
  logic [CHW-1:0] ch_q;
  logic [DW-1:0]  result_q, result_d;

  logic           req_ok, load, op_need, busy, issue_done, r_fire, abort;
  logic           a_valid, b_valid, op_valid;
  logic           a_rdy, b_rdy, op_rdy, r_valid_sel;
  logic [DW-1:0]  a_data, b_data, r_data_sel;
  logic [OPW-1:0] op_data;

  assign req_ok = 32'(REQ_CH) < NCH;
  assign load   = (state_q == StIdle) && REQ_VALID && req_ok;
  assign busy   = (state_q == StIssue) || (state_q == StWait);

  // Per-channel select of handshake inputs for the latched channel.
  always_comb begin
    a_rdy       = 1'b0;
    b_rdy       = 1'b0;
    op_rdy      = 1'b0;
    r_valid_sel = 1'b0;
    r_data_sel  = '0;
    op_need     = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == CHW'(i)) begin
        a_rdy       = A_TREADY[i];
        b_rdy       = B_TREADY[i];
        op_rdy      = OP_TREADY[i];
        r_valid_sel = R_TVALID[i];
        r_data_sel  = R_TDATA[i*DW +: DW];
      end
      if (REQ_CH == CHW'(i)) begin
        op_need = OP_MASK[i];
      end
    end
  end

  assign issue_done = (!a_valid || a_rdy) && (!b_valid || b_rdy) && (!op_valid || op_rdy);
  assign r_fire     = (state_q == StWait) && r_valid_sel;

  core_axis_src_slot #(.W(DW)) u_slot_a (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (load),
    .need      (1'b1),
    .load_data (REQ_A),
    .ready     (a_rdy),
    .flush     (abort),
    .valid     (a_valid),
    .data      (a_data)
  );

  core_axis_src_slot #(.W(DW)) u_slot_b (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (load),
    .need      (1'b1),
    .load_data (REQ_B),
    .ready     (b_rdy),
    .flush     (abort),
    .valid     (b_valid),
    .data      (b_data)
  );

  core_axis_src_slot #(.W(OPW)) u_slot_op (
    .clk       (CLK),
    .rst_n     (RST_N),
    .load      (load),
    .need      (op_need),
    .load_data (REQ_OP),
    .ready     (op_rdy),
    .flush     (abort),
    .valid     (op_valid),
    .data      (op_data)
  );

`ifdef CORE_FPU_TIMEOUT_EN
  logic [TOW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + TOW'(1);
    end
  end

  // A result landing in the expiry cycle still wins so it is not dropped after R_TREADY.
  assign abort = busy && (&cnt_q) && !r_fire;

  always_comb begin
    err_d = err_q;
    if ((state_q == StIdle) && REQ_VALID) begin
      err_d = 1'b0;
    end
    if (abort) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  logic unused_tow;
  assign unused_tow = (TOW == 0);
  assign abort      = 1'b0;
  assign ERR        = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (load) begin
        ch_q <= REQ_CH;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (REQ_VALID) begin
          state_d = req_ok ? StIssue : StRetire;
        end
      end
      StIssue: begin
        if (abort) begin
          state_d = StRetire;
        end else if (issue_done) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (r_fire || abort) begin
          state_d = StRetire;
        end
      end
      StRetire: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    result_d = result_q;
    if ((state_q == StIdle) && REQ_VALID && !req_ok) begin
      result_d = '0;
    end
    if (r_fire) begin
      result_d = r_data_sel;
    end
    if (abort) begin
      result_d = '1;
    end
  end

  always_comb begin
    BUSY      = busy;
    DONE      = (state_q == StRetire);
    RESULT    = result_q;
    A_TVALID  = '0;
    B_TVALID  = '0;
    OP_TVALID = '0;
    R_TREADY  = '0;
    A_TDATA   = '0;
    B_TDATA   = '0;
    OP_TDATA  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == CHW'(i)) begin
        A_TVALID[i]            = a_valid;
        B_TVALID[i]            = b_valid;
        OP_TVALID[i]           = op_valid;
        R_TREADY[i]            = (state_q == StWait);
        A_TDATA[i*DW +: DW]    = a_data;
        B_TDATA[i*DW +: DW]    = b_data;
        OP_TDATA[i*OPW +: OPW] = op_data;
      end
    end
  end

endmodule

// File: tb/tb_core_fpu_dispatch.sv
// Directed self-checking bench for core_fpu_dispatch; timeout scenario runs with CORE_FPU_TIMEOUT_EN.
module tb_core_fpu_dispatch;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 8;
  localparam int unsigned CHW = 3;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic               REQ_VALID;
  logic [CHW-1:0]     REQ_CH;
  logic [DW-1:0]      REQ_A, REQ_B;
  logic [OPW-1:0]     REQ_OP;
  logic               BUSY, DONE, ERR;
  logic [DW-1:0]      RESULT;
  logic [NCH*DW-1:0]  A_TDATA, B_TDATA, R_TDATA;
  logic [NCH*OPW-1:0] OP_TDATA;
  logic [NCH-1:0]     A_TVALID, A_TREADY, B_TVALID, B_TREADY;
  logic [NCH-1:0]     OP_TVALID, OP_TREADY, R_TVALID, R_TREADY;

  int checks   = 0;
  int failures = 0;

  core_fpu_dispatch #(
    .NCH     (NCH),
    .DW      (DW),
    .OPW     (OPW),
    .CHW     (CHW),
    .OP_MASK (4'b1001),
    .TOW     (4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_CH    (REQ_CH),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_OP    (REQ_OP),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RESULT    (RESULT),
    .ERR       (ERR),
    .A_TDATA   (A_TDATA),
    .A_TVALID  (A_TVALID),
    .A_TREADY  (A_TREADY),
    .B_TDATA   (B_TDATA),
    .B_TVALID  (B_TVALID),
    .B_TREADY  (B_TREADY),
    .OP_TDATA  (OP_TDATA),
    .OP_TVALID (OP_TVALID),
    .OP_TREADY (OP_TREADY),
    .R_TDATA   (R_TDATA),
    .R_TVALID  (R_TVALID),
    .R_TREADY  (R_TREADY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_req(input logic [CHW-1:0] ch, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [OPW-1:0] op);
    REQ_VALID = 1'b1;
    REQ_CH    = ch;
    REQ_A     = a;
    REQ_B     = b;
    REQ_OP    = op;
    tick();
    REQ_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got %b exp 000", {BUSY, DONE, ERR});
    end
    checks++;
    if ({A_TVALID, B_TVALID, OP_TVALID, R_TREADY} !== 16'h0) begin
      failures++;
      $display("FAIL reset_valids got %h exp 0000", {A_TVALID, B_TVALID, OP_TVALID, R_TREADY});
    end
    checks++;
    if ((A_TDATA | B_TDATA) !== '0 || OP_TDATA !== '0 || RESULT !== '0) begin
      failures++;
      $display("FAIL reset_data got result %h exp 0", RESULT);
    end
  endtask

  task automatic test_min_latency();
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL lat_idle_busy got %b exp 0", BUSY);
    end
    start_req(3'd0, 32'h3F80_0000, 32'h4000_0000, 8'h00);
    // cycle 1: ISSUE
    checks++;
    if ({BUSY, A_TVALID, B_TVALID, OP_TVALID} !== 13'b1_0001_0001_0001) begin
      failures++;
      $display("FAIL lat_issue got %b exp 1000100010001", {BUSY, A_TVALID, B_TVALID, OP_TVALID});
    end
    checks++;
    if (A_TDATA !== 128'h3F80_0000 || B_TDATA !== 128'h4000_0000) begin
      failures++;
      $display("FAIL lat_tdata got a %h b %h exp 3f800000 40000000", A_TDATA, B_TDATA);
    end
    tick();
    // cycle 2: WAIT
    checks++;
    if ({BUSY, DONE, A_TVALID, R_TREADY} !== 10'b10_0000_0001) begin
      failures++;
      $display("FAIL lat_wait got %b exp 1000000001", {BUSY, DONE, A_TVALID, R_TREADY});
    end
    R_TVALID = 4'b0001;
    R_TDATA  = 128'h4040_0000;
    tick();
    R_TVALID = '0;
    // cycle 3: RETIRE
    checks++;
    if ({DONE, BUSY} !== 2'b10 || RESULT !== 32'h4040_0000) begin
      failures++;
      $display("FAIL lat_done got done %b busy %b res %h exp 1 0 40400000", DONE, BUSY, RESULT);
    end
    tick();
    checks++;
    if (DONE !== 1'b0 || RESULT !== 32'h4040_0000) begin
      failures++;
      $display("FAIL lat_hold got done %b res %h exp 0 40400000", DONE, RESULT);
    end
  endtask

  task automatic test_backpressure();
    B_TREADY = '0;
    start_req(3'd2, 32'h1111_1111, 32'h2222_2222, 8'h14);
    checks++;
    if ({A_TVALID, B_TVALID, OP_TVALID} !== 12'b0100_0100_0000) begin
      failures++;
      $display("FAIL bp_issue got %b exp 010001000000", {A_TVALID, B_TVALID, OP_TVALID});
    end
    for (int k = 2; k <= 6; k++) begin
      tick();
      checks++;
      if ({A_TVALID, B_TVALID, OP_TVALID, R_TREADY} !== 16'h0400 || BUSY !== 1'b1 ||
          B_TDATA !== {32'h0, 32'h2222_2222, 64'h0}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d got v %h b %h exp v 0400", k,
                 {A_TVALID, B_TVALID, OP_TVALID, R_TREADY}, B_TDATA);
      end
    end
    B_TREADY = '1;
    tick();
    // cycle 7: WAIT on channel 2
    checks++;
    if (B_TVALID !== 4'b0000 || R_TREADY !== 4'b0100 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL bp_wait got bv %b rr %b done %b exp 0000 0100 0", B_TVALID, R_TREADY, DONE);
    end
    R_TVALID = 4'b0100;
    R_TDATA  = {32'h0, 32'h3F00_0000, 64'h0};
    tick();
    R_TVALID = '0;
    checks++;
    if (DONE !== 1'b1 || RESULT !== 32'h3F00_0000) begin
      failures++;
      $display("FAIL bp_done got done %b res %h exp 1 3f000000", DONE, RESULT);
    end
    tick();
  endtask

  task automatic test_spurious();
    start_req(3'd1, 32'h4000_0000, 32'h4040_0000, 8'h00);
    checks++;
    if ({A_TVALID, OP_TVALID} !== 8'b0010_0000) begin
      failures++;
      $display("FAIL sp_issue got %b exp 00100000", {A_TVALID, OP_TVALID});
    end
    tick();
    R_TVALID = 4'b1000;
    R_TDATA  = {32'hDEAD_BEEF, 96'h0};
    checks++;
    if (R_TREADY !== 4'b0010) begin
      failures++;
      $display("FAIL sp_rready got %b exp 0010", R_TREADY);
    end
    tick();
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b1 || R_TREADY !== 4'b0010 || RESULT !== 32'h3F00_0000) begin
      failures++;
      $display("FAIL sp_ignore got done %b busy %b rr %b res %h exp 0 1 0010 3f000000",
               DONE, BUSY, R_TREADY, RESULT);
    end
    R_TVALID = 4'b1010;
    R_TDATA  = {32'hDEAD_BEEF, 32'h0, 32'h40A0_0000, 32'h0};
    tick();
    R_TVALID = '0;
    checks++;
    if (DONE !== 1'b1 || RESULT !== 32'h40A0_0000) begin
      failures++;
      $display("FAIL sp_done got done %b res %h exp 1 40a00000", DONE, RESULT);
    end
    // A request held only during RETIRE must not start anything.
    start_req(3'd0, 32'h1, 32'h2, 8'h00);
    checks++;
    if (BUSY !== 1'b0 || A_TVALID !== 4'b0000 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL sp_retire_req got busy %b av %b done %b exp 0 0000 0", BUSY, A_TVALID, DONE);
    end
  endtask

  task automatic test_bad_channel();
    start_req(3'd5, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 8'h01);
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || RESULT !== 32'h0) begin
      failures++;
      $display("FAIL bad_ch_done got done %b busy %b res %h exp 1 0 0", DONE, BUSY, RESULT);
    end
    checks++;
    if ({A_TVALID, B_TVALID, OP_TVALID} !== 12'h000) begin
      failures++;
      $display("FAIL bad_ch_valids got %h exp 000", {A_TVALID, B_TVALID, OP_TVALID});
    end
    tick();
    checks++;
    if (DONE !== 1'b0) begin
      failures++;
      $display("FAIL bad_ch_pulse got %b exp 0", DONE);
    end
  endtask

  task automatic test_reset_mid();
    start_req(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 8'h0C);
    tick();
    checks++;
    if (BUSY !== 1'b1 || R_TREADY !== 4'b1000) begin
      failures++;
      $display("FAIL rm_wait got busy %b rr %b exp 1 1000", BUSY, R_TREADY);
    end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    checks++;
    if ({BUSY, DONE, A_TVALID, B_TVALID, OP_TVALID, R_TREADY} !== 18'h0 || RESULT !== '0) begin
      failures++;
      $display("FAIL rm_cleared got %h res %h exp 0 0",
               {BUSY, DONE, A_TVALID, B_TVALID, OP_TVALID, R_TREADY}, RESULT);
    end
    start_req(3'd3, 32'h3F80_0000, 32'h3F80_0000, 8'h0C);
    checks++;
    if (OP_TVALID !== 4'b1000 || OP_TDATA !== {8'h0C, 24'h0}) begin
      failures++;
      $display("FAIL rm_op got v %b d %h exp 1000 0c000000", OP_TVALID, OP_TDATA);
    end
    tick();
    R_TVALID = 4'b1000;
    R_TDATA  = {32'h0000_0001, 96'h0};
    tick();
    R_TVALID = '0;
    checks++;
    if (DONE !== 1'b1 || RESULT !== 32'h0000_0001 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL rm_done got done %b res %h err %b exp 1 00000001 0", DONE, RESULT, ERR);
    end
    tick();
  endtask

`ifdef CORE_FPU_TIMEOUT_EN
  task automatic test_timeout();
    start_req(3'd1, 32'h5, 32'h6, 8'h00);
    for (int k = 2; k <= 16; k++) begin
      tick();
      checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b1) begin
        failures++;
        $display("FAIL to_pending cycle %0d got done %b busy %b exp 0 1", k, DONE, BUSY);
      end
    end
    tick();
    checks++;
    if (DONE !== 1'b1 || RESULT !== 32'hFFFF_FFFF || ERR !== 1'b1 || R_TREADY !== 4'b0000) begin
      failures++;
      $display("FAIL to_abort got done %b res %h err %b rr %b exp 1 ffffffff 1 0000",
               DONE, RESULT, ERR, R_TREADY);
    end
    tick();
    checks++;
    if (ERR !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky got %b exp 1", ERR);
    end
    start_req(3'd0, 32'h7, 32'h8, 8'h00);
    checks++;
    if (ERR !== 1'b0) begin
      failures++;
      $display("FAIL to_clear got %b exp 0", ERR);
    end
    tick();
    R_TVALID = 4'b0001;
    R_TDATA  = 128'h0000_000F;
    tick();
    R_TVALID = '0;
    checks++;
    if (DONE !== 1'b1 || RESULT !== 32'h0000_000F) begin
      failures++;
      $display("FAIL to_recover got done %b res %h exp 1 0000000f", DONE, RESULT);
    end
    tick();
  endtask
`endif

  initial begin
    RST_N     = 1'b0;
    REQ_VALID = 1'b0;
    REQ_CH    = '0;
    REQ_A     = '0;
    REQ_B     = '0;
    REQ_OP    = '0;
    A_TREADY  = '1;
    B_TREADY  = '1;
    OP_TREADY = '1;
    R_TVALID  = '0;
    R_TDATA   = '0;
    test_reset();
    test_min_latency();
    test_backpressure();
    test_spurious();
    test_bad_channel();
    test_reset_mid();
`ifdef CORE_FPU_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
